// File: rtl/button_press_classifier.sv
// button_press_classifier
//   Turns the debounced key level into single-cycle gesture events: short
//   press, double click, long press, and auto-repeat while the key is held.
//   Each pulse is registered and lasts one cycle. At most one pulse is high
//   in any cycle.
// Ports
//   clk           system clock
//   rst           asynchronous reset, active low
//   key_level     debounced key level (1 = pressed), synchronous to clk
//   short_press   pulse: press+release with no second press inside the gap
//   double_click  pulse: release of the second press of a double click
//   long_press    pulse: key held LONG_CYCLES
//   repeat_tick   pulse every REPEAT_CYCLES while held after long_press
//   busy          level: classifier is not idle
module button_press_classifier #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned LONG_CYCLES   = 80_000_000,
  parameter int unsigned DCLICK_CYCLES = 30_000_000,
  parameter int unsigned REPEAT_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_level,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    HOLD
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_dly_q;
  logic             short_q, short_d;
  logic             dclick_q, dclick_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             busy_q;

  logic             rise, fall;
  logic [CNT_W-1:0] cnt_inc;

  assign rise    = key_level & ~key_dly_q;
  assign fall    = ~key_level & key_dly_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    short_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    // Edge conditions are tested before the timeouts in every state.
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_d = GAP;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HOLD;
          long_d  = 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          state_d = PRESS2;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d  = IDLE;
          dclick_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HOLD;
          long_d  = 1'b1;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_dly_q <= 1'b1;
      short_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_dly_q <= key_level;
      short_q   <= short_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign short_press  = short_q;
  assign double_click = dclick_q;
  assign long_press   = long_q;
  assign repeat_tick  = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench for button_press_classifier with short timing parameters.
// Expected pulses are queued with the cycle they must appear on; a monitor
// compares the pulse vector {short, dclick, long, repeat} every cycle.
module tb_button_press_classifier;

  localparam logic [3:0] EV_SP = 4'b1000;
  localparam logic [3:0] EV_DC = 4'b0100;
  localparam logic [3:0] EV_LP = 4'b0010;
  localparam logic [3:0] EV_RT = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] ev;
  } exp_t;

  logic clk;
  logic rst;
  logic key_level;
  logic short_press, double_click, long_press, repeat_tick, busy;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   failures;

  button_press_classifier #(
    .CNT_W        (32),
    .LONG_CYCLES  (20),
    .DCLICK_CYCLES(10),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_level   (key_level),
    .short_press (short_press),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic [3:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: outputs reflect the posedge just counted in cyc.
  always @(negedge clk) begin
    logic [3:0] exp_ev;
    exp_ev = 4'b0000;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_ev = exp_q[0].ev;
      void'(exp_q.pop_front());
    end
    check_val("events", {28'd0, short_press, double_click, long_press, repeat_tick},
              {28'd0, exp_ev});
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    key_level = 1'b0;

    // 1: reset held while the key toggles, then release with key held high.
    for (int i = 0; i < 6; i++) begin
      key_level = ~key_level;
      step(1);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
    end
    key_level = 1'b1;
    step(1);
    rst = 1'b1;
    step(50);
    check_val("held_thru_rst_busy", {31'd0, busy}, 32'd0);
    key_level = 1'b0;
    step(3);
    check_val("idle_fall_busy", {31'd0, busy}, 32'd0);

    // 2: short press.
    key_level = 1'b1;
    step(2);
    check_val("press_busy", {31'd0, busy}, 32'd1);
    step(3);
    key_level = 1'b0;
    push_ev(cyc + 11, EV_SP);
    step(15);
    check_val("short_done_busy", {31'd0, busy}, 32'd0);

    // 3: double click.
    key_level = 1'b1;
    step(5);
    key_level = 1'b0;
    step(4);
    key_level = 1'b1;
    step(5);
    key_level = 1'b0;
    push_ev(cyc + 1, EV_DC);
    step(15);
    check_val("dclick_done_busy", {31'd0, busy}, 32'd0);

    // 4: long press with four repeat ticks.
    key_level = 1'b1;
    push_ev(cyc + 21, EV_LP);
    push_ev(cyc + 26, EV_RT);
    push_ev(cyc + 31, EV_RT);
    push_ev(cyc + 36, EV_RT);
    push_ev(cyc + 41, EV_RT);
    step(42);
    check_val("hold_busy", {31'd0, busy}, 32'd1);
    key_level = 1'b0;
    step(15);
    check_val("hold_done_busy", {31'd0, busy}, 32'd0);

    // 5: re-press lands exactly on the gap timeout.
    key_level = 1'b1;
    step(5);
    key_level = 1'b0;
    step(10);
    key_level = 1'b1;
    step(5);
    key_level = 1'b0;
    push_ev(cyc + 1, EV_DC);
    step(15);

    // 6: asynchronous reset during HOLD.
    key_level = 1'b1;
    push_ev(cyc + 21, EV_LP);
    step(24);
    check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rst_busy", {31'd0, busy}, 32'd0);
    check_val("async_rst_pulses",
              {28'd0, short_press, double_click, long_press, repeat_tick}, 32'd0);
    step(2);
    rst = 1'b1;
    step(10);
    check_val("post_rst_held_busy", {31'd0, busy}, 32'd0);
    key_level = 1'b0;
    step(5);
    key_level = 1'b1;
    step(5);
    key_level = 1'b0;
    push_ev(cyc + 11, EV_SP);
    step(15);

    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
